// File: rtl/sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sram_port_arbiter
//
// Merges the instruction-fetch and data (load/store) SRAM-like request
// channels onto one shared downstream SRAM-like memory port. The ownership
// of every accepted transaction is tracked in an in-order FIFO, so that each
// returning data_ok/rdata can be steered back to the master that issued it.
//
// Parameters
//   OUTSTANDING  maximum accepted-but-unanswered transactions (power of two, >=1)
//
// Ports
//   clk, reset                         clock, synchronous active-high reset
//   inst_req/wr/size/wstrb/addr/wdata  instruction master request fields
//   inst_addr_ok, inst_data_ok         instruction master handshakes
//   inst_rdata                         instruction read data
//   data_req/wr/size/wstrb/addr/wdata  data master request fields
//   data_addr_ok, data_data_ok         data master handshakes
//   data_rdata                         data read data
//   mem_req/wr/size/wstrb/addr/wdata   muxed downstream request
//   mem_addr_ok                        downstream request accepted
//   mem_data_ok, mem_rdata             downstream in-order response
//   proto_err                          sticky: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module sram_port_arbiter #(
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,

  output logic        proto_err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);

  typedef enum logic {
    OWNER_INST = 1'b0,
    OWNER_DATA = 1'b1
  } owner_e;

  // Pointer increment that wraps at OUTSTANDING; also correct for depth 1,
  // where the pointer simply stays at zero.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(OUTSTANDING - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic             lock_valid;
  owner_e           lock_owner;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  owner_e           owner_mem [OUTSTANDING];

  // -------------------------------------------------------------------------
  // Grant and request path
  // -------------------------------------------------------------------------
  owner_e grant;
  logic   grant_valid;
  logic   fifo_full;
  logic   accept;
  logic   sel_inst;

  // A request that has been offered downstream but not yet taken keeps the
  // port, so a late data_req cannot pull an offered instruction request away.
  // Otherwise data has fixed priority over instruction fetch.
  assign grant       = lock_valid ? lock_owner
                                  : (data_req ? OWNER_DATA : OWNER_INST);
  assign grant_valid = (grant == OWNER_DATA) ? data_req : inst_req;

  // Fullness is taken from the registered count only: a response arriving in
  // the same cycle does not open a slot until the next cycle.
  assign fifo_full   = (count == CNT_W'(OUTSTANDING));

  assign mem_req     = !reset && grant_valid && !fifo_full;
  assign accept      = mem_req && mem_addr_ok;

  // The instruction fields only reach the port while an instruction request
  // is actually being offered; when idle the port mirrors the data master.
  assign sel_inst    = mem_req && (grant == OWNER_INST);

  always_comb begin
    // NOTE: every output of a combinational block is assigned a default up
    // front so that no path through it leaves a value held, which would
    // otherwise infer a latch.
    mem_wr    = data_wr;
    mem_size  = data_size;
    mem_wstrb = data_wstrb;
    mem_addr  = data_addr;
    mem_wdata = data_wdata;
    if (sel_inst) begin
      mem_wr    = inst_wr;
      mem_size  = inst_size;
      mem_wstrb = inst_wstrb;
      mem_addr  = inst_addr;
      mem_wdata = inst_wdata;
    end
  end

  assign inst_addr_ok = accept && (grant == OWNER_INST);
  assign data_addr_ok = accept && (grant == OWNER_DATA);

  // -------------------------------------------------------------------------
  // Response path
  // -------------------------------------------------------------------------
  owner_e head;
  logic   pop;
  logic   spurious;

  assign head     = owner_mem[rd_ptr];
  assign pop      = !reset && mem_data_ok && (count != '0);
  assign spurious = mem_data_ok && (count == '0);

  assign inst_data_ok = pop && (head == OWNER_INST);
  assign data_data_ok = pop && (head == OWNER_DATA);

  // Read data is shared; the data_ok strobes alone qualify it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  // -------------------------------------------------------------------------
  // Control registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of its neighbours.
      lock_valid <= 1'b0;
      lock_owner <= OWNER_INST;
      count      <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      proto_err  <= 1'b0;
    end else begin
      // Lock follows the offered request; a fifo-full stall (mem_req low)
      // leaves it untouched.
      if (mem_req) begin
        if (mem_addr_ok) begin
          lock_valid <= 1'b0;
        end else begin
          lock_valid <= 1'b1;
          lock_owner <= grant;
        end
      end

      if (accept) wr_ptr <= next_ptr(wr_ptr);
      if (pop)    rd_ptr <= next_ptr(rd_ptr);

      unique case ({accept, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (spurious) proto_err <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Owner storage
  // -------------------------------------------------------------------------
  // NOTE: the owner entries are deliberately not reset; only slots between
  // rd_ptr and wr_ptr are ever read, and those are always written first.
  always_ff @(posedge clk) begin
    if (accept) owner_mem[wr_ptr] <= grant;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_port_arbiter
//
// Randomized bench. A stimulus process plays both masters and the downstream
// memory; it predicts which master the port should offer and whether it
// should be offered at all, from the arbitration rules: an offered-but-not-
// taken request keeps the port, otherwise data wins, and nothing is offered
// while OUTSTANDING transactions are unanswered. Each predicted acceptance
// pushes the expected response (owner, read data) on a scoreboard. A separate
// monitor pops and compares whenever the memory returns a response.
// ---------------------------------------------------------------------------
module tb_sram_port_arbiter;

  localparam int OUTSTANDING = 2;
  localparam int RAND_CYCLES = 4000;

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  sram_port_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .proto_err(proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Bench state
  // -------------------------------------------------------------------------
  typedef struct {
    bit          req;
    bit          wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } master_t;

  typedef struct {
    bit          is_data;
    logic [31:0] rdata;
  } resp_t;

  master_t     im, dm;
  resp_t       sb_q[$];        // expected responses, in issue order
  logic [31:0] mem_q[$];       // memory side: read data still owed
  bit          offer_valid;    // an offer was made and not taken
  bit          offer_is_data;
  bit          exp_proto;
  int          ok_pct, rsp_pct;
  int          checks = 0;
  int          passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Contents the memory returns for an address.
  function automatic logic [31:0] mem_image(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0280_0C0C;
  endfunction

  function automatic master_t new_req(input int wr_pct);
    master_t m;
    m.req   = 1'b1;
    m.wr    = ($urandom_range(0, 99) < wr_pct);
    m.size  = 2'($urandom_range(0, 2));
    m.wstrb = 4'($urandom);
    m.addr  = $urandom;
    m.wdata = $urandom;
    return m;
  endfunction

  task automatic apply_masters();
    inst_req = im.req; inst_wr = im.wr; inst_size = im.size;
    inst_wstrb = im.wstrb; inst_addr = im.addr; inst_wdata = im.wdata;
    data_req = dm.req; data_wr = dm.wr; data_size = dm.size;
    data_wstrb = dm.wstrb; data_addr = dm.addr; data_wdata = dm.wdata;
  endtask

  // Drive one cycle of stimulus, just after the rising edge.
  task automatic drive(input bit allow_new, input bit allow_chaos);
    reset = allow_chaos && ($urandom_range(0, 399) == 0);
    if (!im.req) begin
      im = new_req(5);
      im.req = allow_new && ($urandom_range(0, 2) == 0);
    end
    if (!dm.req) begin
      dm = new_req(40);
      dm.req = allow_new && ($urandom_range(0, 3) == 0);
    end
    apply_masters();
    mem_addr_ok = ($urandom_range(0, 99) < ok_pct);
    if (mem_q.size() > 0 && $urandom_range(0, 99) < rsp_pct) begin
      mem_data_ok = 1'b1;
      mem_rdata   = mem_q[0];
    end else if (mem_q.size() == 0 && allow_chaos && $urandom_range(0, 299) == 0) begin
      mem_data_ok = 1'b1;         // spurious response
      mem_rdata   = $urandom;
    end else begin
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
    end
  endtask

  // Predict and check the request side for the current cycle, then advance
  // the bench's view of the world by one clock.
  task automatic request_step();
    bit          g_data, g_valid, e_req, e_acc;
    master_t     g;
    g_data  = offer_valid ? offer_is_data : dm.req;
    g_valid = g_data ? dm.req : im.req;
    e_req   = !reset && g_valid && (mem_q.size() < OUTSTANDING);
    e_acc   = e_req && mem_addr_ok;
    g       = g_data ? dm : im;

    check("mem_req", 32'(mem_req), 32'(e_req));
    if (e_req) begin
      check("mem_addr", mem_addr, g.addr);
      check("mem_wdata", mem_wdata, g.wdata);
      check("mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, g.wr, g.size, g.wstrb});
    end else begin
      check("idle_mem_addr", mem_addr, dm.addr);
      check("idle_mem_ctl", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, dm.wr, dm.size, dm.wstrb});
    end
    check("addr_ok", {30'd0, inst_addr_ok, data_addr_ok},
          {30'd0, e_acc && !g_data, e_acc && g_data});

    if (reset) begin
      offer_valid = 1'b0;
      mem_q.delete();
    end else begin
      if (mem_data_ok && mem_q.size() > 0) void'(mem_q.pop_front());
      if (e_acc) begin
        mem_q.push_back(mem_image(g.addr));
        sb_q.push_back('{is_data: g_data, rdata: mem_image(g.addr)});
        if (g_data) dm.req = 1'b0; else im.req = 1'b0;
        offer_valid = 1'b0;
      end else if (e_req) begin
        offer_valid   = 1'b1;
        offer_is_data = g_data;
      end
    end
  endtask

  task automatic cycle(input bit allow_new, input bit allow_chaos);
    @(posedge clk); #1;
    drive(allow_new, allow_chaos);
    @(negedge clk); #1;
    request_step();
  endtask

  // -------------------------------------------------------------------------
  // Monitor: response side, at the falling edge
  // -------------------------------------------------------------------------
  initial begin
    resp_t r;
    exp_proto = 1'b0;
    forever begin
      @(negedge clk);
      check("proto_err", 32'(proto_err), 32'(exp_proto));
      if (reset) begin
        check("reset_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        sb_q.delete();
        exp_proto = 1'b0;
      end else if (mem_data_ok && sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check("data_ok_route", {30'd0, inst_data_ok, data_data_ok},
              {30'd0, !r.is_data, r.is_data});
        check(r.is_data ? "data_rdata" : "inst_rdata",
              r.is_data ? data_rdata : inst_rdata, r.rdata);
      end else begin
        check("no_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        if (mem_data_ok) exp_proto = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    int guard;
    im = '{default: '0};
    dm = '{default: '0};
    offer_valid = 1'b0;
    offer_is_data = 1'b0;
    ok_pct = 60;
    rsp_pct = 50;
    reset = 1'b1;
    apply_masters();
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Randomized traffic with changing memory behaviour: slow/fast accept,
    // slow responses (FIFO full), and occasional resets and spurious data_ok.
    for (int c = 0; c < RAND_CYCLES; c++) begin
      case ((c / 500) % 4)
        0: begin ok_pct = 60;  rsp_pct = 50; end
        1: begin ok_pct = 100; rsp_pct = 10; end
        2: begin ok_pct = 25;  rsp_pct = 80; end
        default: begin ok_pct = 90; rsp_pct = 35; end
      endcase
      cycle(1'b1, 1'b1);
    end

    // Drain: no new requests; everything pending must complete.
    ok_pct = 100;
    rsp_pct = 100;
    guard = 0;
    while ((im.req || dm.req || mem_q.size() > 0) && guard < 200) begin
      cycle(1'b0, 1'b0);
      guard++;
    end
    check("drain_timeout", 32'(guard < 200), 32'd1);
    cycle(1'b0, 1'b0);
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    // Reset, then a response with nothing outstanding: proto_err must rise
    // and stay set, with no data_ok to either master.
    @(posedge clk); #1;
    reset = 1'b1; mem_data_ok = 1'b0;
    @(negedge clk); #1; request_step();
    @(posedge clk); #1;
    reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk); #1; request_step();
    repeat (3) begin
      @(posedge clk); #1;
      mem_data_ok = 1'b0;
      @(negedge clk); #1; request_step();
    end
    check("proto_err_sticky", 32'(proto_err), 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
